// File: rtl/top_proc_core.sv
// Multicycle RV32I-subset core: IF/ID/EX/MEM/WB FSM, PC, 32x32 regfile,
// immediate generator, ALU and write-back mux. Optional BEQ: TOP_PROC_BEQ_EN.
// Ports: clk, rst (async, active-low), instr <- ROM, PC -> ROM address,
// dAddress/dWriteData/MemRead/MemWrite -> RAM, dReadData <- RAM,
// WriteBackData = value written to rd.
module top_proc_core #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  input  logic [31:0] dReadData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteBackData
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLT, A_SLL, A_SRL,
    A_SRA, A_AND, A_OR, A_XOR
  } alu_t;

  state_t state, state_nx;

  logic [31:0] pc, pc_nx;
  logic [31:0] a, b, imm, res;
  logic [31:0] rf [32];
  alu_t        op;
  logic        use_imm, wen, is_lw, is_sw;
  logic [4:0]  rd;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1v, rs2v;
  logic [31:0] imm_i, imm_s;
  logic        is_r, is_i, is_l, is_s;

  alu_t        d_op;
  logic        d_use, d_wen, d_lw, d_sw;
  logic [31:0] d_imm;

  logic [31:0] opb, alu_y, wb;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  assign rs1v = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2v = (rs2 == 5'd0) ? '0 : rf[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};

  assign is_r = (opc == 7'b0110011);
  assign is_i = (opc == 7'b0010011);
  assign is_l = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_s = (opc == 7'b0100011) && (f3 == 3'b010);

`ifdef TOP_PROC_BEQ_EN
  logic [31:0] imm_b;
  logic        is_b, d_beq, beq, zero;

  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign is_b  = (opc == 7'b1100011) && (f3 == 3'b000);
`endif

  // Decode in ID; anything unrecognised leaves all enables low (NOP).
  always_comb begin
    d_op  = A_ADD;
    d_use = 1'b0;
    d_wen = 1'b0;
    d_lw  = 1'b0;
    d_sw  = 1'b0;
    d_imm = imm_i;
`ifdef TOP_PROC_BEQ_EN
    d_beq = 1'b0;
`endif
    unique case (1'b1)
      is_r: begin
        d_wen = 1'b1;
        unique case ({f7, f3})
          {7'h00, 3'd0}: d_op = A_ADD;
          {7'h20, 3'd0}: d_op = A_SUB;
          {7'h00, 3'd1}: d_op = A_SLL;
          {7'h00, 3'd2}: d_op = A_SLT;
          {7'h00, 3'd4}: d_op = A_XOR;
          {7'h00, 3'd5}: d_op = A_SRL;
          {7'h20, 3'd5}: d_op = A_SRA;
          {7'h00, 3'd6}: d_op = A_OR;
          {7'h00, 3'd7}: d_op = A_AND;
          default:       d_wen = 1'b0;
        endcase
      end
      is_i: begin
        d_wen = 1'b1;
        d_use = 1'b1;
        unique case (f3)
          3'd0: d_op = A_ADD;
          3'd2: d_op = A_SLT;
          3'd4: d_op = A_XOR;
          3'd6: d_op = A_OR;
          3'd7: d_op = A_AND;
          3'd1: begin
            if (f7 == 7'h00) d_op = A_SLL;
            else             d_wen = 1'b0;
          end
          3'd5: begin
            if (f7 == 7'h00)      d_op = A_SRL;
            else if (f7 == 7'h20) d_op = A_SRA;
            else                  d_wen = 1'b0;
          end
          default: d_wen = 1'b0;
        endcase
      end
      is_l: begin
        d_wen = 1'b1;
        d_lw  = 1'b1;
        d_use = 1'b1;
      end
      is_s: begin
        d_sw  = 1'b1;
        d_use = 1'b1;
        d_imm = imm_s;
      end
`ifdef TOP_PROC_BEQ_EN
      // Compare is a SUB on rs1/rs2; imm holds the branch offset.
      is_b: begin
        d_beq = 1'b1;
        d_op  = A_SUB;
        d_imm = imm_b;
      end
`endif
      default: d_wen = 1'b0;
    endcase
  end

  assign opb = use_imm ? imm : b;

  always_comb begin
    alu_y = '0;
    unique case (op)
      A_ADD:   alu_y = a + opb;
      A_SUB:   alu_y = a - opb;
      A_SLT:   alu_y = {31'b0, $signed(a) < $signed(opb)};
      A_SLL:   alu_y = a << opb[4:0];
      A_SRL:   alu_y = a >> opb[4:0];
      A_SRA:   alu_y = $signed(a) >>> opb[4:0];
      A_AND:   alu_y = a & opb;
      A_OR:    alu_y = a | opb;
      A_XOR:   alu_y = a ^ opb;
      default: alu_y = '0;
    endcase
  end

`ifdef TOP_PROC_BEQ_EN
  assign zero  = (res == '0);
  assign pc_nx = (beq && zero) ? pc + imm : pc + 32'd4;
`else
  assign pc_nx = pc + 32'd4;
`endif

  assign wb = is_lw ? dReadData : res;

  always_comb begin
    state_nx = S_IF;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    unique case (state)
      S_IF:  state_nx = S_ID;
      S_ID:  state_nx = S_EX;
      S_EX:  state_nx = S_MEM;
      S_MEM: begin
        state_nx = S_WB;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB:    state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IF;
      pc      <= INITIAL_PC;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      res     <= '0;
      op      <= A_ADD;
      use_imm <= 1'b0;
      wen     <= 1'b0;
      is_lw   <= 1'b0;
      is_sw   <= 1'b0;
      rd      <= '0;
`ifdef TOP_PROC_BEQ_EN
      beq     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == S_ID) begin
        a       <= rs1v;
        b       <= rs2v;
        imm     <= d_imm;
        op      <= d_op;
        use_imm <= d_use;
        wen     <= d_wen;
        is_lw   <= d_lw;
        is_sw   <= d_sw;
        rd      <= instr[11:7];
`ifdef TOP_PROC_BEQ_EN
        beq     <= d_beq;
`endif
      end
      if (state == S_EX) res <= alu_y;
      if (state == S_WB) pc  <= pc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && wen && rd != 5'd0) begin
      rf[rd] <= wb;
    end
  end

  assign PC            = pc;
  assign dAddress      = res;
  assign dWriteData    = b;
  assign WriteBackData = wb;

endmodule

// File: tb/tb_top_proc_core.sv
// Bench for top_proc_core: ROM/RAM models, ISA-level reference model,
// per-cycle compare process and literal expectations per instruction.
module tb_top_proc_core;

  localparam logic [31:0] IPC = 32'h0040_0000;
  localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  localparam int FINAL = 19;

  logic        clk, rst;
  logic [31:0] instr, PC, dAddress, dWriteData, dReadData, WriteBackData;
  logic        MemRead, MemWrite;

  logic [31:0] rom [128];
  logic [31:0] ram [64];
  logic [31:0] mreg [32];
  logic [31:0] mmem [64];
  logic [31:0] mpc;
  logic [31:0] lit [32];
  bit          lit_v [32];

  int compared, mismatched;
  int ph, prev_idx;
  bit run, at_final;

  top_proc_core #(.INITIAL_PC(IPC)) dut (
    .clk(clk), .rst(rst), .instr(instr), .PC(PC),
    .dAddress(dAddress), .dWriteData(dWriteData),
    .dReadData(dReadData), .MemRead(MemRead),
    .MemWrite(MemWrite), .WriteBackData(WriteBackData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr     <= rom[PC[8:2]];
    dReadData <= ram[dAddress[7:2]];
    if (MemWrite) ram[dAddress[7:2]] <= dWriteData;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(logic [11:0] im, logic [4:0] r1,
      logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {im, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] er(logic [6:0] f7, logic [4:0] r2,
      logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] es(logic [11:0] im, logic [4:0] r2,
      logic [4:0] r1);
    return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] eb(logic [12:0] im, logic [4:0] r2,
      logic [4:0] r1);
    return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  // ISA-level reference: what one instruction does to architectural state.
  task automatic model_step(input logic [31:0] ins, input logic [31:0] pc,
      output int kind, output logic [31:0] val, output logic [31:0] addr,
      output logic [31:0] sd, output logic [31:0] npc);
    logic [31:0] x, y, im;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    x  = mreg[ins[19:15]];
    y  = mreg[ins[24:20]];
    im = {{20{ins[31]}}, ins[31:20]};
    kind = K_NOP;
    val  = '0;
    addr = '0;
    sd   = '0;
    npc  = pc + 32'd4;
    if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h13) y = im;
      sh = y[4:0];
      kind = K_ALU;
      case (f3)
        3'd0: if (op == 7'h13 || f7 == 7'h00) val = x + y;
              else if (f7 == 7'h20) val = x - y;
              else kind = K_NOP;
        3'd1: if (f7 == 7'h00) val = x << sh; else kind = K_NOP;
        3'd2: if (op == 7'h13 || f7 == 7'h00)
                val = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
              else kind = K_NOP;
        3'd4: if (op == 7'h13 || f7 == 7'h00) val = x ^ y;
              else kind = K_NOP;
        3'd5: if (f7 == 7'h00) val = x >> sh;
              else if (f7 == 7'h20) val = $signed(x) >>> sh;
              else kind = K_NOP;
        3'd6: if (op == 7'h13 || f7 == 7'h00) val = x | y;
              else kind = K_NOP;
        3'd7: if (op == 7'h13 || f7 == 7'h00) val = x & y;
              else kind = K_NOP;
        default: kind = K_NOP;
      endcase
      if (kind == K_NOP) val = '0;
    end else if (op == 7'h03 && f3 == 3'd2) begin
      kind = K_LW;
      addr = x + im;
      val  = mmem[addr[7:2]];
    end else if (op == 7'h23 && f3 == 3'd2) begin
      kind = K_SW;
      addr = x + {{20{ins[31]}}, ins[31:25], ins[11:7]};
      sd   = y;
    end
`ifdef TOP_PROC_BEQ_EN
    else if (op == 7'h63 && f3 == 3'd0) begin
      kind = K_BEQ;
      if (x == y)
        npc = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                    ins[11:8], 1'b0};
    end
`endif
  endtask

  always @(negedge clk) begin
    int          kind, idx;
    logic [31:0] val, addr, sd, npc;
    if (run) begin
      idx = int'(mpc[8:2]);
      model_step(rom[idx], mpc, kind, val, addr, sd, npc);
      chk("pc", PC, mpc);
      chk("mem_read", {31'b0, MemRead}, {31'b0, ph == 3 && kind == K_LW});
      chk("mem_write", {31'b0, MemWrite}, {31'b0, ph == 3 && kind == K_SW});
      if (ph == 0 && prev_idx == 9)
`ifdef TOP_PROC_BEQ_EN
        chk("beq_taken_pc", PC, IPC + 32'd44);
`else
        chk("beq_disabled_pc", PC, IPC + 32'd40);
`endif
      if (ph == 0 && prev_idx == 11)
        chk("beq_not_taken_pc", PC, IPC + 32'd48);
      if (ph == 3 && (kind == K_LW || kind == K_SW))
        chk("d_address", dAddress, addr);
      if (ph == 3 && kind == K_SW) begin
        chk("d_write_data", dWriteData, sd);
        if (idx == 5) begin
          chk("sw_lit_addr", dAddress, 32'd8);
          chk("sw_lit_data", dWriteData, 32'd5);
        end
      end
      if (ph == 4 && (kind == K_ALU || kind == K_LW)) begin
        chk("wb_data", WriteBackData, val);
        if (lit_v[idx]) chk("wb_literal", WriteBackData, lit[idx]);
      end
      if (ph == 3 && idx == FINAL) at_final = 1'b1;
      if (ph == 4) begin
        if ((kind == K_ALU || kind == K_LW) && rom[idx][11:7] != 5'd0)
          mreg[rom[idx][11:7]] = val;
        if (kind == K_SW) mmem[addr[7:2]] = sd;
        mpc = npc;
        prev_idx = idx;
      end
      ph = (ph == 4) ? 0 : ph + 1;
    end
  end

  initial begin
    compared = 0;
    mismatched = 0;
    run = 1'b0;
    at_final = 1'b0;
    ph = 0;
    prev_idx = -1;
    rst = 1'b0;
    instr = '0;
    dReadData = '0;
    mpc = IPC;
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      mmem[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      lit[i] = '0;
      lit_v[i] = 1'b0;
    end

    rom[0]  = 32'h00500093;
    rom[1]  = ei(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13);
    rom[2]  = er(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    rom[3]  = er(7'h00, 5'd1, 5'd2, 3'd2, 5'd4);
    rom[4]  = ei(12'h401, 5'd2, 3'd5, 5'd5, 7'h13);
    rom[5]  = es(12'd8, 5'd1, 5'd0);
    rom[6]  = ei(12'd8, 5'd0, 3'd2, 5'd6, 7'h03);
    rom[7]  = ei(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);
    rom[8]  = er(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
    rom[9]  = eb(13'd8, 5'd1, 5'd1);
    rom[10] = ei(12'd1, 5'd0, 3'd0, 5'd8, 7'h13);
    rom[11] = eb(13'd8, 5'd2, 5'd1);
    rom[12] = ei(12'd9, 5'd0, 3'd0, 5'd9, 7'h13);
    rom[13] = er(7'h20, 5'd2, 5'd1, 3'd0, 5'd10);
    rom[14] = ei(12'd3, 5'd1, 3'd1, 5'd11, 7'h13);
    rom[15] = er(7'h00, 5'd1, 5'd2, 3'd5, 5'd12);
    rom[16] = er(7'h00, 5'd2, 5'd1, 3'd4, 5'd13);
    rom[17] = er(7'h00, 5'd2, 5'd1, 3'd3, 5'd14);
    rom[18] = er(7'h00, 5'd0, 5'd6, 3'd0, 5'd15);
    rom[19] = es(12'd12, 5'd1, 5'd0);

    lit[0]  = 32'd5;         lit_v[0]  = 1'b1;
    lit[1]  = 32'hFFFFFFFD;  lit_v[1]  = 1'b1;
    lit[2]  = 32'd2;         lit_v[2]  = 1'b1;
    lit[3]  = 32'd1;         lit_v[3]  = 1'b1;
    lit[4]  = 32'hFFFFFFFE;  lit_v[4]  = 1'b1;
    lit[6]  = 32'd5;         lit_v[6]  = 1'b1;
    lit[7]  = 32'd7;         lit_v[7]  = 1'b1;
    lit[8]  = 32'd0;         lit_v[8]  = 1'b1;
    lit[10] = 32'd1;         lit_v[10] = 1'b1;
    lit[12] = 32'd9;         lit_v[12] = 1'b1;
    lit[13] = 32'd8;         lit_v[13] = 1'b1;
    lit[14] = 32'h28;        lit_v[14] = 1'b1;
    lit[15] = 32'h07FFFFFF;  lit_v[15] = 1'b1;
    lit[16] = 32'hFFFFFFF8;  lit_v[16] = 1'b1;
    lit[18] = 32'd5;         lit_v[18] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", PC, IPC);
    chk("reset_mem_read", {31'b0, MemRead}, 32'd0);
    chk("reset_mem_write", {31'b0, MemWrite}, 32'd0);

    @(negedge clk);
    #1;
    rst = 1'b1;
    ph  = 1;
    run = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    chk("pc_after_5", PC, IPC + 32'd4);

    for (int i = 0; i < 300 && !at_final; i++) begin
      @(negedge clk);
      #1;
    end

    if (!at_final) begin
      chk("final_sw_reached", 32'd0, 32'd1);
    end else begin
      chk("sw_write_pre_reset", {31'b0, MemWrite}, 32'd1);
      rst = 1'b0;
      run = 1'b0;
      #1;
      chk("mid_reset_mem_write", {31'b0, MemWrite}, 32'd0);
      chk("mid_reset_mem_read", {31'b0, MemRead}, 32'd0);
      chk("mid_reset_pc", PC, IPC);
      repeat (3) @(posedge clk);
      #1;
      chk("ram_untouched", ram[3], 32'd0);
      chk("ram_sw_word", ram[2], 32'd5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/top_proc_core.md
# top_proc_core

Multicycle 32-bit RISC-V (RV32I subset) processor core. It is the top of the processor datapath and connects to an external instruction ROM and data RAM, both with a one-cycle synchronous read. Every instruction takes exactly five clock cycles, sequenced by an FSM: IF, ID, EX, MEM, WB. The block contains the FSM, PC register, 32×32 register file, immediate generator, ALU and write-back mux.

## Interface
- INITIAL_PC, default 32'h0040_0000: PC value loaded on reset.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr  input  32  instruction word from the ROM. Valid from the cycle after IF.
- PC  output  32  current program counter. Drives the ROM address (the low 9 bits are used externally).
- dAddress  output  32  data RAM address, equal to the ALU result.
- dWriteData  output  32  store data, equal to rs2 read data.
- dReadData  input  32  data RAM read data. Valid from the cycle after MEM.
- MemRead  output  1  high only in MEM for LW.
- MemWrite  output  1  high only in MEM for SW. Acts as the RAM write enable.
- WriteBackData  output  32  value written to rd. It is dReadData for LW, otherwise the ALU result.

## Operation
- Supported instructions:
  - R-type: ADD, SUB, SLT, SLL, SRL, SRA, AND, OR, XOR.
  - I-type: ADDI, SLTI, SLLI, SRLI, SRAI, ANDI, ORI, XORI.
  - Memory: LW, SW.
  - Branch: BEQ (see Configuration).
- Any other opcode or funct combination executes as a NOP: no register write, no memory access, PC+4.
- Immediates are sign-extended in I, S and B formats. The B-type immediate has an implied bit0 = 0.
- ALU arithmetic:
  - All arithmetic is 32-bit and wraps modulo 2^32.
  - SLT and SLTI are signed and yield 1 or 0.
  - Shift amount is operand[4:0] (shamt for immediate shifts). SRA/SRAI are arithmetic shifts.
- ALU zero flag = (result == 0). SUB is used for the BEQ compare.
- Register file:
  - Two combinational read ports and one write port.
  - x0 always reads 0; writes to x0 are discarded.
  - The write occurs at the rising edge ending WB, only for R-type, I-type ALU and LW.
- PC update happens at the rising edge ending WB:
  - PC+sext(immB) when BEQ is taken.
  - PC+4 otherwise.
- MemRead and MemWrite are registered or FSM-decoded so they are glitch-free. Both are low in every state except MEM.

## Timing
- FSM sequence: IF→ID→EX→MEM→WB→IF, unconditional. No stalls.
- IF: PC is stable on the PC output; the ROM registers instr at the end of IF.
- ID: decode, register file read, immediate generation. Operands are latched at the end of ID.
- EX: ALU operation; the result is latched at the end of EX.
- MEM: dAddress and dWriteData are stable.
  - SW: MemWrite=1 for exactly one cycle.
  - LW: MemRead=1; data is available in WB.
- WB: WriteBackData is valid; register write and PC update at the end of WB.
- Reset (asynchronous, active-low, takes effect mid-instruction as well):
  - FSM=IF, PC=INITIAL_PC, all registers = 0, internal latches = 0.
  - MemRead=0, MemWrite=0.
  - An in-flight instruction is aborted with no register or memory side effects.
- Reset release: the first instruction's IF begins at the first rising edge after rst goes high. N instructions complete in 5N cycles.

## Configuration
- TOP_PROC_BEQ_EN:
  - Defined: BEQ is decoded; taken when rs1==rs2, target PC+sext(immB).
  - Undefined: opcode 1100011 executes as a NOP (PC+4). The zero-flag branch logic is not compiled.

## Test plan
- Reset: hold rst=0 for 2 cycles, release. Required: PC=INITIAL_PC, MemRead=MemWrite=0, first fetch at INITIAL_PC, PC=INITIAL_PC+4 after 5 cycles.
- ALU: ADDI x1,x0,5 then ADDI x2,x0,-3 then ADD x3,x1,x2. Required: WriteBackData 5, -3 (0xFFFFFFFD), 2 in the respective WB cycles. Also SLT x4,x2,x1 → 1 and SRAI x5,x2,1 → 0xFFFFFFFE.
- Memory round trip: SW x1,8(x0) then LW x6,8(x0). Required: MemWrite=1 for one MEM cycle with dAddress=8, dWriteData=5; LW WriteBackData=5; x6=5.
- x0 protection: ADDI x0,x0,7 then ADD x7,x0,x0. Required: WriteBackData for the second instruction = 0.
- Branch, with TOP_PROC_BEQ_EN defined: BEQ x1,x1,+8. Required: PC advances by 8. BEQ x1,x2,+8 advances by 4. With the macro undefined, both advance by 4.
- Reset mid-op: assert rst=0 during the MEM state of an SW. Required: MemWrite drops immediately, RAM is unchanged, PC=INITIAL_PC.
